// File: rtl/vs_mux_rr_arbiter.sv
// vs_mux_rr_arbiter: four-way round-robin arbiter feeding one shared
// 4:1 data mux and a one-entry valid/ready output buffer.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   in_valid[3:0]    per-requester valid (bit i = requester i)
//   in_data0..3      per-requester data, WIDTH bits each
//   in_ready[3:0]    per-requester ready, one-hot or zero
//   out_valid        output buffer holds a word
//   out_data         buffered word
//   out_sel          requester index that supplied out_data
//   out_ready        consumer accepts out_data
//   xfer_count       completed output transfers, wraps at 2^CNT_WIDTH
module vs_mux_rr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           in_valid,
    input  logic [WIDTH-1:0]     in_data0,
    input  logic [WIDTH-1:0]     in_data1,
    input  logic [WIDTH-1:0]     in_data2,
    input  logic [WIDTH-1:0]     in_data3,
    output logic [3:0]           in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           out_sel,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] xfer_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE =
        {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q;
    logic   [1:0]           ptr_q;
    logic   [WIDTH-1:0]     data_q;
    logic   [1:0]           sel_q;
    logic   [CNT_WIDTH-1:0] cnt_q;

    logic   [7:0]           valid_dbl;
    logic   [7:0]           valid_shf;
    logic   [3:0]           valid_rot;
    logic   [1:0]           offset;
    logic   [1:0]           grant;
    logic   [WIDTH-1:0]     mux_data;
    logic                   any_valid;
    logic                   can_accept;
    logic                   in_xfer;
    logic                   out_xfer;

    // Rotate the request vector so that bit 0 is the requester the
    // pointer currently favours; the first set bit is then the
    // distance from ptr to the winner.
    always_comb begin
        valid_dbl = {in_valid, in_valid};
        valid_shf = valid_dbl >> ptr_q;
        valid_rot = valid_shf[3:0];
    end

    always_comb begin
        offset = 2'd0;
        if (valid_rot[0]) begin
            offset = 2'd0;
        end else if (valid_rot[1]) begin
            offset = 2'd1;
        end else if (valid_rot[2]) begin
            offset = 2'd2;
        end else if (valid_rot[3]) begin
            offset = 2'd3;
        end
    end

    // Two-bit add wraps naturally back to the absolute index.
    assign grant = ptr_q + offset;

    always_comb begin
        mux_data = '0;
        unique case (grant)
            2'd0: mux_data = in_data0;
            2'd1: mux_data = in_data1;
            2'd2: mux_data = in_data2;
            2'd3: mux_data = in_data3;
            default: mux_data = '0;
        endcase
    end

    assign any_valid  = |in_valid;
    assign can_accept = (state_q == EMPTY) || out_ready;
    assign in_xfer    = can_accept && any_valid;
    assign out_xfer   = (state_q == FULL) && out_ready;

    // Reset gates the ready bits directly so requesters see no
    // acceptance while the block is held in reset.
    always_comb begin
        in_ready = 4'b0000;
        if (rst_n && in_xfer) begin
            in_ready = 4'b0001 << grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= 2'd0;
            data_q  <= '0;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            if (out_xfer) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    // A simultaneous refill keeps the buffer full.
                    if (out_xfer && !in_xfer) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
            if (in_xfer) begin
                data_q <= mux_data;
                sel_q  <= grant;
                ptr_q  <= grant + 2'd1;
            end
        end
    end

    assign out_valid  = (state_q == FULL);
    assign out_data   = data_q;
    assign out_sel    = sel_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_vs_mux_rr_arbiter.sv
// Testbench for vs_mux_rr_arbiter: scenario tasks plus randomized
// traffic, all checked against a transaction-level arbiter model.
module tb_vs_mux_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [3:0]  dat [4];
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;
    logic [15:0] xfer_count;

    logic [3:0]  in_ready_w;
    logic        out_valid_w;
    logic [3:0]  out_data_w;
    logic [1:0]  out_sel_w;
    logic [3:0]  cnt_w;

    int total = 0;
    int bad   = 0;

    // model state
    int       m_ptr;
    bit       m_ov;
    bit [3:0] m_od;
    bit [1:0] m_os;
    int       m_cnt;

    logic [3:0] obs_ready;
    logic [3:0] exp_ready;

    vs_mux_rr_arbiter #(.WIDTH(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_data0(dat[0]), .in_data1(dat[1]),
        .in_data2(dat[2]), .in_data3(dat[3]),
        .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready), .xfer_count(xfer_count)
    );

    vs_mux_rr_arbiter #(.WIDTH(4), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_data0(dat[0]), .in_data1(dat[1]),
        .in_data2(dat[2]), .in_data3(dat[3]),
        .in_ready(in_ready_w), .out_valid(out_valid_w),
        .out_data(out_data_w), .out_sel(out_sel_w),
        .out_ready(out_ready), .xfer_count(cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [26:0] obs_tuple();
        return {out_valid, out_data, out_sel, xfer_count, cnt_w};
    endfunction

    function automatic logic [26:0] exp_tuple();
        bit [31:0] c;
        c = m_cnt;
        return {m_ov, m_od, m_os, c[15:0], c[3:0]};
    endfunction

    function automatic int model_grant();
        for (int k = 0; k < 4; k++) begin
            if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_ov = 0; m_od = 0; m_os = 0; m_cnt = 0;
    endtask

    // Called at posedge+1; returns at the next posedge+1 with the
    // model advanced by one clock edge.
    task automatic step();
        int g;
        bit acc, ox;
        #1;
        obs_ready = in_ready;
        g   = model_grant();
        acc = (!m_ov || out_ready) && (in_valid != 4'b0);
        exp_ready = acc ? 4'(1 << g) : 4'b0;
        ox  = m_ov && out_ready;
        @(posedge clk);
        if (ox) m_cnt++;
        if (acc) begin
            m_od  = dat[g];
            m_os  = 2'(g);
            m_ov  = 1'b1;
            m_ptr = (g + 1) % 4;
        end else if (ox) begin
            m_ov = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        in_valid = 4'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [26:0] o;
        rst_n = 1'b0;
        in_valid = 4'hF;
        out_ready = 1'b1;
        model_reset();
        #3;
        total++;
        o = obs_tuple();
        if (o !== 27'b0 || in_ready !== 4'b0) begin
            bad++;
            $display("FAIL reset_init: got out=%h rdy=%b want 0", o, in_ready);
        end
        in_valid = 4'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 4'hF;
        step();
        step();
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre: out_valid=%b want 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        o = obs_tuple();
        if (o !== 27'b0 || in_ready !== 4'b0) begin
            bad++;
            $display("FAIL reset_mid: got out=%h rdy=%b want 0", o, in_ready);
        end
        in_valid = 4'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 4'hF;
        step();
        total++;
        if (out_sel !== 2'd0 || out_data !== 4'd2 || obs_ready !== 4'b0001) begin
            bad++;
            $display("FAIL reset_first: sel=%0d data=%0d rdy=%b want 0 2 0001",
                     out_sel, out_data, obs_ready);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        in_valid = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (out_sel !== 2'(i % 4) || out_data !== 4'((i % 4 + 1) * 2)
                || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL rr_seq[%0d]: sel=%0d data=%0d want %0d %0d",
                         i, out_sel, out_data, i % 4, (i % 4 + 1) * 2);
            end
        end
        in_valid = 4'b0;
        step();
        total++;
        if (xfer_count !== 16'd8 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rr_count: cnt=%0d ov=%b want 8 0",
                     xfer_count, out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 4'b0100;
        out_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (obs_ready !== 4'b0 || out_valid !== 1'b1 || out_data !== 4'd6
                || out_sel !== 2'd2) begin
                bad++;
                $display("FAIL bp_hold[%0d]: rdy=%b ov=%b data=%0d want 0000 1 6",
                         i, obs_ready, out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        step();
        total++;
        if (obs_ready !== 4'b0100 || xfer_count !== 16'd1 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: rdy=%b cnt=%0d ov=%b want 0100 1 1",
                     obs_ready, xfer_count, out_valid);
        end
        in_valid = 4'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_pointer_skip();
        do_reset();
        out_ready = 1'b1;
        in_valid = 4'b0001;
        step();
        in_valid = 4'b1001;
        step();
        total++;
        if (out_data !== 4'd8 || out_sel !== 2'd3) begin
            bad++;
            $display("FAIL skip_a: data=%0d sel=%0d want 8 3", out_data, out_sel);
        end
        step();
        total++;
        if (out_data !== 4'd2 || out_sel !== 2'd0) begin
            bad++;
            $display("FAIL skip_b: data=%0d sel=%0d want 2 0", out_data, out_sel);
        end
        in_valid = 4'hF;
        step();
        total++;
        if (out_sel !== 2'd1) begin
            bad++;
            $display("FAIL skip_ptr: sel=%0d want 1", out_sel);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        in_valid = 4'b0001;
        out_ready = 1'b0;
        step();
        in_valid = 4'b0010;
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b1 || out_data !== 4'd4 || xfer_count !== 16'd1) begin
            bad++;
            $display("FAIL simul: ov=%b data=%0d cnt=%0d want 1 4 1",
                     out_valid, out_data, xfer_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        in_valid = 4'hF;
        out_ready = 1'b1;
        repeat (17) step();
        in_valid = 4'b0;
        step();
        total++;
        if (cnt_w !== 4'd1 || xfer_count !== 16'd17) begin
            bad++;
            $display("FAIL wrap: cnt4=%0d cnt16=%0d want 1 17", cnt_w, xfer_count);
        end
    endtask

    task automatic test_random();
        logic [26:0] o, e;
        do_reset();
        for (int i = 0; i < 4; i++) dat[i] = 4'($urandom);
        in_valid = 4'($urandom);
        for (int n = 0; n < 400; n++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            step();
            total++;
            if (obs_ready !== exp_ready) begin
                bad++;
                $display("FAIL rnd_ready[%0d]: got %b want %b", n, obs_ready, exp_ready);
            end
            total++;
            o = obs_tuple();
            e = exp_tuple();
            if (o !== e) begin
                bad++;
                $display("FAIL rnd_out[%0d]: got %h want %h", n, o, e);
            end
            // Accepted requesters may drop or change; others must hold.
            for (int i = 0; i < 4; i++) begin
                if (exp_ready[i] || !in_valid[i]) begin
                    in_valid[i] = 1'($urandom);
                    dat[i] = 4'($urandom);
                end
            end
        end
        in_valid = 4'b0;
        for (int i = 0; i < 4; i++) dat[i] = 4'((i + 1) * 2);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) dat[i] = 4'((i + 1) * 2);
        in_valid = 4'b0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_pointer_skip();
        test_simultaneous();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vs_mux_rr_arbiter.md
# vs_mux_rr_arbiter

Round-robin arbiter and output register that shares a single 4:1 multiplexer path between four valid/ready requesters. Each cycle it picks one pending requester, steers that requester's data through the mux, and captures it in a one-entry output buffer. The buffer drives a single valid/ready consumer. The block sits in front of the comb_logic multiplexers wherever several producers contend for one downstream port.

## Interface
- WIDTH, default 4: data width of every requester and of the output.
- CNT_WIDTH, default 16: width of the transfer counter.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  4  per-requester valid; bit i belongs to requester i.
- in_data0..in_data3  input  WIDTH each  per-requester data.
- in_ready  output  4  per-requester ready; at most one bit set.
- out_valid  output  1  output buffer holds a word.
- out_data  output  WIDTH  buffered word.
- out_sel  output  2  index of the requester that supplied out_data.
- out_ready  input  1  consumer accepts out_data.
- xfer_count  output  CNT_WIDTH  number of completed output transfers.

## Operation
- Two-state buffer FSM, encoded by out_valid: EMPTY (0) and FULL (1).
- can_accept = EMPTY, or (FULL and out_ready).
- Rotating priority pointer ptr[1:0], reset value 0.
- grant is the first index in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with in_valid set.
- in_ready[grant] = can_accept and at least one in_valid bit set. All other in_ready bits are 0.
- in_ready is combinational from in_valid, ptr, out_valid and out_ready.
- An input transfer occurs when in_valid[i] and in_ready[i] are both 1. On the clock edge:
  - out_data <= in_data[grant]
  - out_sel <= grant
  - out_valid <= 1
  - ptr <= grant+1 (mod 4)
- An output transfer occurs when out_valid and out_ready are both 1. On the clock edge:
  - xfer_count increments, wrapping modulo 2^CNT_WIDTH.
  - If there is no simultaneous input transfer, out_valid <= 0. out_data and out_sel hold their values.
- Simultaneous input and output transfer: out_valid stays 1 and the new word replaces the old one. This gives full throughput with no bubble.
- FULL with out_ready=0: all in_ready bits are 0, and out_data/out_sel are held stable until accepted.
- No input transfer: ptr is unchanged, so an idle cycle does not rotate priority.
- Requesters must hold in_valid and in_data until accepted. The arbiter never drops a presented word.
- Reset values, applied asynchronously when rst_n=0: out_valid=0, out_data=0, out_sel=0, xfer_count=0, ptr=0.
- Reset mid-operation discards any buffered word. in_ready is 0 while rst_n=0.

## Timing
- Latency is 1 cycle from input acceptance to out_valid.
- Sustained throughput is 1 word per cycle while out_ready=1.
- Fairness: with all four requesters continuously valid and out_ready=1, grants run 0,1,2,3,0,… Each requester is served once per 4 transfers.
- A lone requester is granted every cycle.
- Reset deassertion takes effect synchronously to clk. The first acceptance can occur on the first rising edge after rst_n rises.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1 → out_valid=0, out_data=0, out_sel=0, xfer_count=0, in_ready=0 immediately, without waiting for a clock edge. After release, the first grant goes to requester 0.
- Round robin: in_dataI=(I+1)*2, all in_valid=1, out_ready=1 for 8 cycles → out_data sequence 2,4,6,8,2,4,6,8; out_sel 0,1,2,3,0,1,2,3; xfer_count=8.
- Backpressure: only requester 2 valid (data 6), out_ready=0 for 5 cycles → out_valid=1, out_data=6 stable, in_ready=0000 after the first accept. Then out_ready=1 for one cycle → xfer_count=1 and exactly one further word is accepted.
- Pointer skip: ptr=1 (after a grant to requester 0), in_valid=1001 → grant goes to requester 3 (out_data=8), then to requester 0 (out_data=2). ptr ends at 1.
- Simultaneous events: FULL with out_ready=1 and requester 1 valid → out_valid stays 1, out_data changes to 4 on the same edge, and xfer_count increments by 1.
- Counter wrap: CNT_WIDTH=4, 17 transfers → xfer_count=1.
